onchip_mem_mp: RTL and testbench
================================

// Module: onchip_mem_mp
// PURPOSE
// - Parametrised multi-port 8..N-bit on-chip RAM for the bilinear datapath: NRD read lanes, NWR write lanes, one clock.
// - Adds read-valid tracking, selectable read latency and deterministic write-collision resolution with a counter.
// - Adds write-through bypass and a sequential fill engine that initialises the array without host traffic.
// - Sits between the pixel fetch/store units and the image buffer. Successor of the fixed 4R/4W 8-bit RAM.
// PARAMETERS
// ADDR_W   12    address width; DEPTH = 2**ADDR_W
// DATA_W   8     word width (1..32)
// NRD      4     read lanes (1..8)
// NWR      4     write lanes (1..8)
// RD_LAT   1     read latency in cycles, legal values 1 or 2 (2 = extra output register)
// BYPASS   0     1: a read returns same-cycle winning write data on address match
// PORTS
// clk         in   1            rising-edge clock
// rst         in   1            asynchronous active-high reset
// ren         in   NRD          per-lane read request
// raddr       in   NRD*ADDR_W   lane i at [i*ADDR_W +: ADDR_W]
// rdata       out  NRD*DATA_W   lane i read data
// rvalid      out  NRD          lane i data valid; a one-cycle strobe per request
// we          in   NWR          per-lane write enable
// waddr       in   NWR*ADDR_W   write addresses
// wdata       in   NWR*DATA_W   write data
// fill_start  in   1            pulse: begin fill of whole array
// fill_value  in   DATA_W       fill word; sampled on accepted fill_start
// fill_busy   out  1            fill in progress
// fill_done   out  1            one-cycle pulse at fill completion
// coll_pulse  out  1            one-cycle pulse, cycle after any write-address collision
// coll_cnt    out  16           saturating count of collision cycles
// BEHAVIOUR
// - Reset values: rdata=0, rvalid=0, fill_busy=0, fill_done=0, coll_pulse=0, coll_cnt=0, FSM=IDLE.
// - Reset does not clear array contents; only fill clears them.
// - Reads are synchronous and read-before-write:
//   - ren[i] at edge T gives rvalid[i]=1 and rdata[i] at T+RD_LAT.
//   - rdata holds its last value when rvalid=0.
// - Writes commit at the edge where we=1.
// - Collisions: if two or more asserted lanes share an address, the lowest index lane wins; the others are dropped.
//   - Each collision cycle asserts coll_pulse once (one pulse per cycle, not per pair).
//   - coll_cnt increments by 1 and saturates at 16'hFFFF.
// - BYPASS=1: read lane address == winning write address in the same cycle -> rdata = that wdata.
// - BYPASS=0: the same case returns the old contents.
// - Fill FSM states: IDLE -> FILL -> DONE -> IDLE.
//   - IDLE: fill_start=1 latches fill_value, clears the address counter and moves to FILL; fill_busy=1 from the next cycle.
//   - FILL: writes fill_value to NWR consecutive addresses per cycle (counter += NWR). When the last DEPTH-1 address is written -> DONE.
//   - The final chunk is masked when DEPTH is not a multiple of NWR.
//   - DONE: fill_done=1 and fill_busy=0 for one cycle, then IDLE.
//   - Fill duration is ceil(DEPTH/NWR) cycles in FILL.
//   - fill_start during FILL or DONE is ignored (no restart, no queueing).
//   - During FILL, external we is ignored entirely (no commit, no collision count). Reads stay serviced and return old or filled words.
//   - rst mid-fill: the FSM goes to IDLE immediately, fill_done is not pulsed, and the array is left partially filled.
// - Address counter width is ADDR_W+1 so the end detection cannot wrap.
// STRUCTURE
// - Package dsa_mem_pkg holds:
//   - typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_t;
//   - localparam COLL_CNT_W = 16;
//   - function is_pow2 for parameter checks.
// - Sub-module mem_fill_fsm: owns the state, address counter, latched value, busy/done and per-lane fill write ports.
// - The top muxes fill ports over external ports while busy.
// - The array is inferred (ramstyle "M10K"); no vendor primitives.
// - Elaboration $error fires on illegal RD_LAT, NRD or NWR.
// TESTING
// - Basic R/W (RD_LAT=1): we0 addr 0x010=0xA5, next cycle ren0 addr 0x010 -> rvalid0 one cycle later with rdata0=0xA5.
// - Latency (RD_LAT=2): ren on all 4 lanes at cycle T -> rvalid=4'hF exactly at T+2, zero at T+1 and T+3.
// - Collision: we0/we2 both to 0x020, data 0x11/0x22 -> read 0x020 returns 0x11; coll_pulse for 1 cycle; coll_cnt=1.
// - Bypass: BYPASS=1, addr 0x030 holds 0x00; same-cycle we0=0x7E and ren1 to 0x030 -> rdata1=0x7E. With BYPASS=0 -> 0x00.
// - Fill: ADDR_W=4, NWR=3, fill_value=0x5C:
//   - fill_busy for ceil(16/3)=6 cycles, then fill_done pulses once.
//   - All 16 words read back 0x5C; a concurrent external we is ignored.
// - Reset mid-fill: rst at fill cycle 3 -> fill_busy=0 and coll_cnt=0 immediately; fill_done never asserted; a new fill_start then completes normally.

Source files
------------

// File: rtl/dsa_mem_pkg.sv
// Shared types and constants for the multi-port on-chip RAM.
//   fill_state_t : fill engine states (idle, running, one-cycle done)
//   COLL_CNT_W   : width of the saturating write-collision counter
//   is_pow2      : elaboration-time helper for parameter checks
package dsa_mem_pkg;

    typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_t;

    localparam int COLL_CNT_W = 16;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/onchip_mem_mp_if.sv
// Bus bundle for onchip_mem_mp: read lanes, write lanes, fill control and
// collision status. Lane i of a flat vector sits at [i*W +: W].
//   master : the fetch/store side (drives requests, observes responses)
//   slave  : the RAM
interface onchip_mem_mp_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NRD    = 4,
    parameter int NWR    = 4
);
    import dsa_mem_pkg::*;

    logic [NRD-1:0]         ren;
    logic [NRD*ADDR_W-1:0]  raddr;
    logic [NRD*DATA_W-1:0]  rdata;
    logic [NRD-1:0]         rvalid;
    logic [NWR-1:0]         we;
    logic [NWR*ADDR_W-1:0]  waddr;
    logic [NWR*DATA_W-1:0]  wdata;
    logic                   fill_start;
    logic [DATA_W-1:0]      fill_value;
    logic                   fill_busy;
    logic                   fill_done;
    logic                   coll_pulse;
    logic [COLL_CNT_W-1:0]  coll_cnt;

    modport master (
        output ren, raddr, we, waddr, wdata, fill_start, fill_value,
        input  rdata, rvalid, fill_busy, fill_done, coll_pulse, coll_cnt
    );

    modport slave (
        input  ren, raddr, we, waddr, wdata, fill_start, fill_value,
        output rdata, rvalid, fill_busy, fill_done, coll_pulse, coll_cnt
    );

endinterface

// File: rtl/mem_fill_fsm.sv
// Sequential fill engine: writes one latched word to every address of the
// array, NWR consecutive addresses per cycle, without host traffic.
//   clk, rst          : clock, asynchronous active-high reset
//   fill_start        : start request, honoured only when idle
//   fill_value        : word latched on an accepted start
//   fill_busy         : high for every cycle spent in FILL_RUN
//   fill_done         : one-cycle pulse after the last chunk
//   fill_we/waddr/wdata : per-lane write ports, muxed in by the top while busy
module mem_fill_fsm
    import dsa_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NWR    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill_start,
    input  logic [DATA_W-1:0]      fill_value,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [NWR-1:0]         fill_we,
    output logic [NWR*ADDR_W-1:0]  fill_waddr,
    output logic [NWR*DATA_W-1:0]  fill_wdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    // One spare bit so the chunk base can never wrap back to zero.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NWR_C = CNT_W'(NWR);

    fill_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic                last_chunk;

    // Integer arithmetic keeps the end test exact even when NWR > DEPTH.
    assign last_chunk = (int'(cnt_q) + NWR) >= DEPTH;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        case (state_q)
            FILL_IDLE: begin
                if (fill_start) begin
                    state_d = FILL_RUN;
                    cnt_d   = '0;
                    val_d   = fill_value;
                end
            end
            FILL_RUN: begin
                cnt_d = cnt_q + NWR_C;
                if (last_chunk) state_d = FILL_DONE;
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= FILL_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

    assign fill_busy = (state_q == FILL_RUN);
    assign fill_done = (state_q == FILL_DONE);

    // Lane j covers cnt+j; lanes past the top of the array are masked off.
    always_comb begin
        int a;
        a          = 0;
        fill_we    = '0;
        fill_waddr = '0;
        fill_wdata = '0;
        for (int j = 0; j < NWR; j++) begin
            a = int'(cnt_q) + j;
            fill_we[j]                      = fill_busy && (a < DEPTH);
            fill_waddr[j*ADDR_W +: ADDR_W]  = ADDR_W'(a);
            fill_wdata[j*DATA_W +: DATA_W]  = val_q;
        end
    end

endmodule

// File: rtl/onchip_mem_mp.sv
// Multi-port on-chip RAM: NRD synchronous read lanes (read-before-write,
// latency 1 or 2), NWR write lanes with lowest-lane-wins collision handling,
// optional write-through bypass and a built-in array fill engine.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : onchip_mem_mp_if slave (read/write lanes, fill, collision status)
module onchip_mem_mp
    import dsa_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NRD    = 4,
    parameter int NWR    = 4,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    onchip_mem_mp_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("onchip_mem_mp: RD_LAT must be 1 or 2");
        end
        if (NRD < 1 || NRD > 8) begin : g_bad_nrd
            $error("onchip_mem_mp: NRD must be 1..8");
        end
        if (NWR < 1 || NWR > 8) begin : g_bad_nwr
            $error("onchip_mem_mp: NWR must be 1..8");
        end
        if (DATA_W < 1 || DATA_W > 32) begin : g_bad_dw
            $error("onchip_mem_mp: DATA_W must be 1..32");
        end
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("onchip_mem_mp: DEPTH must be a power of two");
        end
    endgenerate

    // ---------------- fill engine and write-port mux ----------------
    logic                   fill_busy, fill_done;
    logic [NWR-1:0]         fill_we;
    logic [NWR*ADDR_W-1:0]  fill_waddr;
    logic [NWR*DATA_W-1:0]  fill_wdata;

    mem_fill_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWR(NWR)) u_fill (
        .clk        (clk),
        .rst        (rst),
        .fill_start (bus.fill_start),
        .fill_value (bus.fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_we    (fill_we),
        .fill_waddr (fill_waddr),
        .fill_wdata (fill_wdata)
    );

    // External writes are ignored entirely while the fill owns the array.
    logic [NWR-1:0]         we_sel;
    logic [NWR*ADDR_W-1:0]  waddr_sel;
    logic [NWR*DATA_W-1:0]  wdata_sel;

    assign we_sel    = fill_busy ? fill_we    : bus.we;
    assign waddr_sel = fill_busy ? fill_waddr : bus.waddr;
    assign wdata_sel = fill_busy ? fill_wdata : bus.wdata;

    // ---------------- collision resolution ----------------
    // A lane loses if any lower-index active lane targets the same address,
    // so at most one winning write exists per address in a cycle.
    logic [NWR-1:0] wr_win;
    logic           coll_now;

    always_comb begin
        wr_win   = '0;
        coll_now = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (we_sel[j]) begin
                wr_win[j] = 1'b1;
                for (int k = 0; k < j; k++) begin
                    if (we_sel[k] &&
                        waddr_sel[k*ADDR_W +: ADDR_W] == waddr_sel[j*ADDR_W +: ADDR_W])
                        wr_win[j] = 1'b0;
                end
                if (!wr_win[j]) coll_now = 1'b1;
            end
        end
    end

    logic                   coll_pulse_q;
    logic [COLL_CNT_W-1:0]  coll_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_pulse_q <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            // Fill lanes are consecutive and never collide; gate anyway so fill
            // traffic can never be counted.
            coll_pulse_q <= coll_now && !fill_busy;
            if (coll_now && !fill_busy && coll_cnt_q != '1)
                coll_cnt_q <= coll_cnt_q + COLL_CNT_W'(1);
        end
    end

    // ---------------- storage ----------------
    (* ramstyle = "M10K" *) logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents change only through writes or the fill engine.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NWR; j++) begin
            if (wr_win[j]) mem[waddr_sel[j*ADDR_W +: ADDR_W]] <= wdata_sel[j*DATA_W +: DATA_W];
        end
    end

    // ---------------- read path ----------------
    // Read-before-write: the array read sees pre-edge contents; bypass
    // substitutes the single winning write for a matching address.
    logic [DATA_W-1:0] rd_word [NRD];

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_word[i] = mem[bus.raddr[i*ADDR_W +: ADDR_W]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_win[j] &&
                        waddr_sel[j*ADDR_W +: ADDR_W] == bus.raddr[i*ADDR_W +: ADDR_W])
                        rd_word[i] = wdata_sel[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    logic [DATA_W-1:0] rd1_data [NRD];
    logic [NRD-1:0]    rd1_valid;

    // Data registers load only on a request so rdata holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_valid <= '0;
            for (int i = 0; i < NRD; i++) rd1_data[i] <= '0;
        end else begin
            rd1_valid <= bus.ren;
            for (int i = 0; i < NRD; i++)
                if (bus.ren[i]) rd1_data[i] <= rd_word[i];
        end
    end

    logic [DATA_W-1:0] out_data [NRD];
    logic [NRD-1:0]    out_valid;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_data [NRD];
            logic [NRD-1:0]    rd2_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd2_valid <= '0;
                    for (int i = 0; i < NRD; i++) rd2_data[i] <= '0;
                end else begin
                    rd2_valid <= rd1_valid;
                    for (int i = 0; i < NRD; i++)
                        if (rd1_valid[i]) rd2_data[i] <= rd1_data[i];
                end
            end

            assign out_data  = rd2_data;
            assign out_valid = rd2_valid;
        end else begin : g_lat1
            assign out_data  = rd1_data;
            assign out_valid = rd1_valid;
        end
    endgenerate

    for (genvar i = 0; i < NRD; i++) begin : g_rd_out
        assign bus.rdata[i*DATA_W +: DATA_W] = out_data[i];
    end

    assign bus.rvalid     = out_valid;
    assign bus.fill_busy  = fill_busy;
    assign bus.fill_done  = fill_done;
    assign bus.coll_pulse = coll_pulse_q;
    assign bus.coll_cnt   = coll_cnt_q;

endmodule

// File: tb/tb_onchip_mem_mp.sv
// Bench for onchip_mem_mp. Three instances cover the configurations:
//   a : ADDR_W=12 NWR=4 RD_LAT=1 BYPASS=0  (basic R/W, read-before-write, collisions)
//   b : ADDR_W=12 NWR=4 RD_LAT=2 BYPASS=1  (latency, bypass)
//   c : ADDR_W=4  NWR=3 RD_LAT=1 BYPASS=0  (fill engine, reset mid-fill)
// Read requests push {instance, lane, due cycle, data} into a scoreboard;
// a negedge monitor pops and compares whenever rvalid is seen.
module tb_onchip_mem_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_mem_mp_if #(.ADDR_W(12), .DATA_W(8), .NRD(4), .NWR(4)) if_a ();
    onchip_mem_mp_if #(.ADDR_W(12), .DATA_W(8), .NRD(4), .NWR(4)) if_b ();
    onchip_mem_mp_if #(.ADDR_W(4),  .DATA_W(8), .NRD(4), .NWR(3)) if_c ();

    onchip_mem_mp #(.ADDR_W(12), .DATA_W(8), .NRD(4), .NWR(4), .RD_LAT(1), .BYPASS(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    onchip_mem_mp #(.ADDR_W(12), .DATA_W(8), .NRD(4), .NWR(4), .RD_LAT(2), .BYPASS(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    onchip_mem_mp #(.ADDR_W(4),  .DATA_W(8), .NRD(4), .NWR(3), .RD_LAT(1), .BYPASS(0))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        int         dut;
        int         lane;
        int         due;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0]  rv_all [3];
    logic [31:0] rd_all [3];
    assign rv_all[0] = if_a.rvalid;
    assign rv_all[1] = if_b.rvalid;
    assign rv_all[2] = if_c.rvalid;
    assign rd_all[0] = if_a.rdata;
    assign rd_all[1] = if_b.rdata;
    assign rd_all[2] = if_c.rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 2 ns after a rising edge; the next edge samples them.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        if_a.we = '0; if_a.ren = '0; if_a.fill_start = 1'b0;
        if_b.we = '0; if_b.ren = '0; if_b.fill_start = 1'b0;
        if_c.we = '0; if_c.ren = '0; if_c.fill_start = 1'b0;
    endtask

    task automatic wr(input int d, input int lane, input int addr, input logic [7:0] v);
        case (d)
            0: begin
                if_a.we[lane] = 1'b1;
                if_a.waddr[lane*12 +: 12] = 12'(addr);
                if_a.wdata[lane*8 +: 8] = v;
            end
            1: begin
                if_b.we[lane] = 1'b1;
                if_b.waddr[lane*12 +: 12] = 12'(addr);
                if_b.wdata[lane*8 +: 8] = v;
            end
            default: begin
                if_c.we[lane] = 1'b1;
                if_c.waddr[lane*4 +: 4] = 4'(addr);
                if_c.wdata[lane*8 +: 8] = v;
            end
        endcase
    endtask

    task automatic rd(input int d, input int lane, input int addr, input logic [7:0] v);
        case (d)
            0: begin if_a.ren[lane] = 1'b1; if_a.raddr[lane*12 +: 12] = 12'(addr); end
            1: begin if_b.ren[lane] = 1'b1; if_b.raddr[lane*12 +: 12] = 12'(addr); end
            default: begin if_c.ren[lane] = 1'b1; if_c.raddr[lane*4 +: 4] = 4'(addr); end
        endcase
        // Request sampled at edge cyc+1; data visible after edge cyc+RD_LAT.
        sb.push_back('{d, lane, cyc + ((d == 1) ? 2 : 1), v});
    endtask

    // Full fill of instance c with poking: external writes (including a
    // colliding pair) during FILL, restart attempts during FILL and DONE,
    // and fill_value changed right after the accepted start.
    task automatic fill_c(input logic [7:0] v, input logic [7:0] bad_v);
        int busy_n;
        int done_n;
        int coll_seen;
        int done_at;
        int last_busy;
        busy_n = 0; done_n = 0; coll_seen = 0; done_at = -1; last_busy = -1;
        if_c.fill_value = v;
        if_c.fill_start = 1'b1;
        step();
        if_c.fill_start = 1'b0;
        if_c.fill_value = bad_v;
        for (int t = 0; t < 14; t++) begin
            if (if_c.fill_busy) begin busy_n++; last_busy = t; end
            if (if_c.fill_done) begin done_n++; done_at = t; end
            if (if_c.coll_pulse) coll_seen++;
            clr();
            if (if_c.fill_busy) begin
                wr(2, 0, 5, 8'hEE);
                wr(2, 1, 5, 8'hEF);
                wr(2, 2, 15, 8'hE2);
            end
            if_c.fill_start = (if_c.fill_busy && busy_n == 2) || if_c.fill_done;
            step();
        end
        clr();
        check("fill_busy_cycles", busy_n, 6);
        check("fill_done_pulses", done_n, 1);
        check("fill_done_after_busy", done_at, last_busy + 1);
        check("fill_no_coll_pulse", coll_seen, 0);
        check("fill_coll_cnt", if_c.coll_cnt, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        int hit;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                for (int l = 0; l < 4; l++) begin
                    if (rv_all[d][l]) begin
                        hit = -1;
                        for (int k = 0; k < sb.size(); k++) begin
                            if (sb[k].dut == d && sb[k].lane == l) begin
                                hit = k;
                                break;
                            end
                        end
                        n_vec++;
                        if (hit < 0) begin
                            n_miss++;
                            $display("FAIL rd_unexpected dut%0d lane%0d: rvalid=1 at cyc %0d, expected 0", d, l, cyc);
                        end else begin
                            if (rd_all[d][l*8 +: 8] !== sb[hit].data || cyc != sb[hit].due) begin
                                n_miss++;
                                $display("FAIL rd_data dut%0d lane%0d: got 0x%0h at cyc %0d, expected 0x%0h at cyc %0d",
                                         d, l, rd_all[d][l*8 +: 8], cyc, sb[hit].data, sb[hit].due);
                            end
                            sb.delete(hit);
                        end
                    end
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due < cyc) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rd_missing dut%0d lane%0d: no rvalid by cyc %0d, expected 0x%0h at cyc %0d",
                             sb[k].dut, sb[k].lane, cyc, sb[k].data, sb[k].due);
                    sb.delete(k);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_n;
        int busy_n;
        clr();
        if_a.raddr = '0; if_a.waddr = '0; if_a.wdata = '0; if_a.fill_value = '0;
        if_b.raddr = '0; if_b.waddr = '0; if_b.wdata = '0; if_b.fill_value = '0;
        if_c.raddr = '0; if_c.waddr = '0; if_c.wdata = '0; if_c.fill_value = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // ---- reset values ----
        check("rst_rvalid_a", if_a.rvalid, 0);
        check("rst_rdata_a", if_a.rdata, 0);
        check("rst_rdata_b", if_b.rdata, 0);
        check("rst_fill_busy_c", if_c.fill_busy, 0);
        check("rst_fill_done_c", if_c.fill_done, 0);
        check("rst_coll_pulse_a", if_a.coll_pulse, 0);
        check("rst_coll_cnt_a", if_a.coll_cnt, 0);
        rst = 1'b0;
        step();

        // ---- a: basic write then read ----
        wr(0, 0, 'h010, 8'hA5); step(); clr();
        rd(0, 0, 'h010, 8'hA5); step(); clr();
        for (int l = 0; l < 4; l++) wr(0, l, 'h100 + l, 8'(8'h10 + l * 'h11));
        step(); clr();
        for (int l = 0; l < 4; l++) rd(0, l, 'h103 - l, 8'(8'h10 + (3 - l) * 'h11));
        step(); clr();

        // ---- a: read-before-write without bypass ----
        wr(0, 0, 'h030, 8'h00); step(); clr();
        wr(0, 0, 'h030, 8'h7E); rd(0, 1, 'h030, 8'h00); step(); clr();
        rd(0, 1, 'h030, 8'h7E); step(); clr();

        // ---- a: collisions ----
        wr(0, 0, 'h020, 8'h11); wr(0, 2, 'h020, 8'h22); wr(0, 1, 'h021, 8'h33);
        step(); clr();
        check("coll_pulse_hi_1", if_a.coll_pulse, 1);
        check("coll_cnt_1", if_a.coll_cnt, 1);
        step();
        check("coll_pulse_lo_1", if_a.coll_pulse, 0);
        check("coll_cnt_hold_1", if_a.coll_cnt, 1);
        rd(0, 0, 'h020, 8'h11); rd(0, 3, 'h021, 8'h33); step(); clr();
        // three lanes on one address: still one pulse, one count
        wr(0, 0, 'h040, 8'hC0); wr(0, 1, 'h040, 8'hC1); wr(0, 3, 'h040, 8'hC3); wr(0, 2, 'h041, 8'hC2);
        step(); clr();
        check("coll_pulse_hi_2", if_a.coll_pulse, 1);
        check("coll_cnt_2", if_a.coll_cnt, 2);
        step();
        check("coll_pulse_lo_2", if_a.coll_pulse, 0);
        rd(0, 2, 'h040, 8'hC0); rd(0, 1, 'h041, 8'hC2); step(); clr();
        // collision not involving lane 0: lane 1 wins
        wr(0, 1, 'h050, 8'hD1); wr(0, 3, 'h050, 8'hD3); step(); clr();
        check("coll_cnt_3", if_a.coll_cnt, 3);
        rd(0, 0, 'h050, 8'hD1); step(); clr();

        // ---- b: RD_LAT=2 ----
        for (int l = 0; l < 4; l++) wr(1, l, 'h200 + l, 8'(8'hB0 + l));
        step(); clr();
        for (int l = 0; l < 4; l++) rd(1, l, 'h200 + l, 8'(8'hB0 + l));
        step(); clr();
        step(); step();
        rd(1, 0, 'h201, 8'hB1); step(); clr();
        rd(1, 0, 'h202, 8'hB2); step(); clr();

        // ---- b: bypass ----
        wr(1, 0, 'h030, 8'h00); step(); clr();
        wr(1, 0, 'h030, 8'h7E); rd(1, 1, 'h030, 8'h7E); step(); clr();
        wr(1, 0, 'h031, 8'h55); wr(1, 2, 'h031, 8'h66); rd(1, 3, 'h031, 8'h55); step(); clr();
        rd(1, 2, 'h031, 8'h55); step(); clr();
        repeat (3) step();

        // ---- c: full fill ----
        fill_c(8'h5C, 8'h99);
        for (int base = 0; base < 16; base += 4) begin
            for (int l = 0; l < 4; l++) rd(2, l, base + l, 8'h5C);
            step(); clr();
        end

        // ---- c: reset mid-fill ----
        wr(2, 0, 2, 8'h01); wr(2, 1, 2, 8'h02); wr(2, 2, 15, 8'h11); step(); clr();
        check("c_coll_cnt_pre", if_c.coll_cnt, 1);
        wr(2, 0, 0, 8'h22); step(); clr();
        if_c.fill_value = 8'hA7;
        if_c.fill_start = 1'b1;
        step();
        if_c.fill_start = 1'b0;
        check("midfill_busy_c1", if_c.fill_busy, 1);
        step();
        step();
        check("midfill_busy_c3", if_c.fill_busy, 1);
        rst = 1'b1;
        #1;
        check("midfill_rst_busy", if_c.fill_busy, 0);
        check("midfill_rst_coll_cnt", if_c.coll_cnt, 0);
        step();
        rst = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int t = 0; t < 8; t++) begin
            if (if_c.fill_done) done_n++;
            if (if_c.fill_busy) busy_n++;
            step();
        end
        check("midfill_no_done", done_n, 0);
        check("midfill_stays_idle", busy_n, 0);
        rd(2, 0, 0, 8'hA7); rd(2, 1, 5, 8'hA7); rd(2, 2, 6, 8'h5C); rd(2, 3, 15, 8'h11);
        step(); clr();
        rd(2, 0, 2, 8'hA7); step(); clr();

        // ---- c: fresh fill after the aborted one ----
        fill_c(8'h3D, 8'h99);
        rd(2, 0, 15, 8'h3D); rd(2, 1, 0, 8'h3D); rd(2, 2, 6, 8'h3D); rd(2, 3, 9, 8'h3D);
        step(); clr();

        repeat (4) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
